// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: four buffered result producers share three register-file
// write ports, granted round-robin with no two writes to one register per cycle.
module wb_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            hold,
  input  logic [3:0]                      req_valid,
  output logic [3:0]                      req_ready,
  input  logic [11:0]                     req_waddr,
  input  logic [63:0]                     req_wdata,
  input  logic [23:0]                     req_wrob,
  output logic                            wen0,
  output logic                            wen1,
  output logic                            wen2,
  output logic [2:0]                      waddr0,
  output logic [2:0]                      waddr1,
  output logic [2:0]                      waddr2,
  output logic [15:0]                     wdata0,
  output logic [15:0]                     wdata1,
  output logic [15:0]                     wdata2,
  output logic [5:0]                      wrob0,
  output logic [5:0]                      wrob1,
  output logic [5:0]                      wrob2,
  output logic [4*($clog2(DEPTH)+1)-1:0]  occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [2:0]    mem_addr [4][DEPTH];
  logic [15:0]   mem_data [4][DEPTH];
  logic [5:0]    mem_rob  [4][DEPTH];
  logic [AW-1:0] wr_ptr   [4];
  logic [AW-1:0] rd_ptr   [4];
  logic [OW-1:0] cnt      [4];

  logic [3:0]    push;
  logic [3:0]    pop;
  logic [2:0]    head_addr [4];
  logic [15:0]   head_data [4];
  logic [5:0]    head_rob  [4];

  logic [1:0]    rr_ptr;
  logic [1:0]    grant_cnt;
  logic [1:0]    last_idx;
  logic [1:0]    idx;
  logic          conflict;
  logic [2:0]    sel_valid;
  logic [2:0]    sel_addr [3];
  logic [15:0]   sel_data [3];
  logic [5:0]    sel_rob  [3];

  logic [2:0]    wen_q;
  logic [2:0]    addr_q [3];
  logic [15:0]   data_q [3];
  logic [5:0]    rob_q  [3];

  // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_ready[i] = (cnt[i] < OW'(DEPTH)) && !flush && !reset;
      push[i]      = req_valid[i] && req_ready[i];
      head_addr[i] = mem_addr[i][rd_ptr[i]];
      head_data[i] = mem_data[i][rd_ptr[i]];
      head_rob[i]  = mem_rob[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i]] <= req_waddr[3*i +: 3];
        mem_data[i][wr_ptr[i]] <= req_wdata[16*i +: 16];
        mem_rob[i][wr_ptr[i]]  <= req_wrob[6*i +: 6];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + OW'(1);
          2'b01:   cnt[i] <= cnt[i] - OW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Walk heads from the round-robin pointer; a head whose register is already
  // being written this cycle is skipped and stays put for a later cycle.
  always_comb begin
    pop       = '0;
    grant_cnt = '0;
    last_idx  = rr_ptr;
    idx       = rr_ptr;
    conflict  = 1'b0;
    sel_valid = '0;
    for (int k = 0; k < 3; k++) begin
      sel_addr[k] = '0;
      sel_data[k] = '0;
      sel_rob[k]  = '0;
    end
    if (!hold && !flush && !reset) begin
      for (int k = 0; k < 4; k++) begin
        idx      = rr_ptr + 2'(k);
        conflict = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (2'(j) < grant_cnt && sel_addr[j] == head_addr[idx]) conflict = 1'b1;
        end
        if (cnt[idx] != '0 && grant_cnt < 2'd3 && !conflict) begin
          sel_valid[grant_cnt] = 1'b1;
          sel_addr[grant_cnt]  = head_addr[idx];
          sel_data[grant_cnt]  = head_data[idx];
          sel_rob[grant_cnt]   = head_rob[idx];
          pop[idx]             = 1'b1;
          last_idx             = idx;
          grant_cnt            = grant_cnt + 2'd1;
        end
      end
    end
  end

  // Unused ports keep their payload; only the enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      wen_q  <= '0;
      for (int k = 0; k < 3; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
        rob_q[k]  <= '0;
      end
    end else if (flush) begin
      rr_ptr <= '0;
      wen_q  <= '0;
    end else begin
      wen_q <= sel_valid;
      for (int k = 0; k < 3; k++) begin
        if (sel_valid[k]) begin
          addr_q[k] <= sel_addr[k];
          data_q[k] <= sel_data[k];
          rob_q[k]  <= sel_rob[k];
        end
      end
      if (grant_cnt != 2'd0) rr_ptr <= last_idx + 2'd1;
    end
  end

  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign waddr0 = addr_q[0];
  assign waddr1 = addr_q[1];
  assign waddr2 = addr_q[2];
  assign wdata0 = data_q[0];
  assign wdata1 = data_q[1];
  assign wdata2 = data_q[2];
  assign wrob0  = rob_q[0];
  assign wrob1  = rob_q[1];
  assign wrob2  = rob_q[2];

  for (genvar i = 0; i < 4; i++) begin : g_occ
    assign occ[i*OW +: OW] = cnt[i];
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a table of per-cycle vectors whose
// expectations go through a scoreboard queue, plus a bounded latency sequence.
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        hold;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_waddr;
  logic [63:0] req_wdata;
  logic [23:0] req_wrob;
  logic        wen0, wen1, wen2;
  logic [2:0]  waddr0, waddr1, waddr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [5:0]  wrob0, wrob1, wrob2;
  logic [7:0]  occ;

  wb_port_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wrob(req_wrob),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wrob0(wrob0), .wrob1(wrob1), .wrob2(wrob2),
    .occ(occ)
  );

  typedef struct {
    int          id;
    logic        rst;
    logic        fl;
    logic        hd;
    logic [3:0]  v;
    logic [11:0] a;
    logic [63:0] d;
    logic [23:0] r;
    logic [2:0]  ewen;
    logic [8:0]  ea;
    logic [47:0] ed;
    logic [17:0] er;
    logic [7:0]  eocc;
    logic [3:0]  erdy;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t cur;
  int   tests_run;
  int   tests_failed;

  localparam logic [11:0] FA = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [63:0] FD = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
  localparam logic [23:0] FR = {6'd19, 6'd18, 6'd17, 6'd16};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic fl, input logic hd,
                              input logic [3:0] v, input logic [11:0] a,
                              input logic [63:0] d, input logic [23:0] r,
                              input logic [2:0] ewen, input logic [8:0] ea,
                              input logic [47:0] ed, input logic [17:0] er,
                              input logic [7:0] eocc, input logic [3:0] erdy);
    vec_t t;
    t.id = 0; t.rst = rst; t.fl = fl; t.hd = hd; t.v = v; t.a = a; t.d = d; t.r = r;
    t.ewen = ewen; t.ea = ea; t.ed = ed; t.er = er; t.eocc = eocc; t.erdy = erdy;
    return t;
  endfunction

  task automatic cmp(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    reset     = t.rst;
    flush     = t.fl;
    hold      = t.hd;
    req_valid = t.v;
    req_waddr = t.a;
    req_wdata = t.d;
    req_wrob  = t.r;
    exp_q.push_back(t);
  endtask

  task automatic checkOutput(input vec_t e);
    logic [8:0]  pa;
    logic [47:0] pd;
    logic [17:0] pr;
    pa = {waddr2, waddr1, waddr0};
    pd = {wdata2, wdata1, wdata0};
    pr = {wrob2, wrob1, wrob0};
    cmp("wen", e.id, 64'({wen2, wen1, wen0}), 64'(e.ewen));
    for (int k = 0; k < 3; k++) begin
      if (e.ewen[k]) begin
        cmp($sformatf("waddr%0d", k), e.id, 64'(pa[3*k +: 3]), 64'(e.ea[3*k +: 3]));
        cmp($sformatf("wdata%0d", k), e.id, 64'(pd[16*k +: 16]), 64'(e.ed[16*k +: 16]));
        cmp($sformatf("wrob%0d", k), e.id, 64'(pr[6*k +: 6]), 64'(e.er[6*k +: 6]));
      end
    end
    cmp("occ", e.id, 64'(occ), 64'(e.eocc));
    cmp("req_ready", e.id, 64'(req_ready), 64'(e.erdy));
  endtask

  // Scoreboard side: each expectation is consumed just after the edge its stimulus reached.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int lat;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    req_valid = '0; req_waddr = '0; req_wdata = '0; req_wrob = '0;

    // reset, then one push per requester, two grant cycles
    vecs.push_back(mk(1,0,0, 4'b0000, '0, '0, '0, 3'b000, '0, '0, '0, 8'h00, 4'b0000));
    vecs.push_back(mk(0,0,0, 4'b1111, {3'd4,3'd3,3'd2,3'd1}, {16'hA004,16'hA003,16'hA002,16'hA001},
                      {6'd8,6'd7,6'd6,6'd5}, 3'b000, '0, '0, '0, 8'h55, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b111, {3'd3,3'd2,3'd1},
                      {16'hA003,16'hA002,16'hA001}, {6'd7,6'd6,6'd5}, 8'h40, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b001, {6'd0,3'd4}, {32'h0,16'hA004},
                      {12'd0,6'd8}, 8'h00, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b000, '0, '0, '0, 8'h00, 4'b1111));
    // same-register conflict
    vecs.push_back(mk(0,0,0, 4'b0111, {3'd0,3'd6,3'd5,3'd5}, {16'd0,16'd33,16'd22,16'd11},
                      {6'd0,6'd3,6'd2,6'd1}, 3'b000, '0, '0, '0, 8'h15, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b011, {3'd0,3'd6,3'd5}, {16'd0,16'd33,16'd11},
                      {6'd0,6'd3,6'd1}, 8'h04, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b001, {6'd0,3'd5}, {32'h0,16'd22},
                      {12'd0,6'd2}, 8'h00, 4'b1111));
    // backpressure under hold
    vecs.push_back(mk(0,0,1, 4'b0100, {3'd0,3'd7,6'd0}, {16'h0,16'h0C01,32'h0}, {6'd0,6'd9,12'd0},
                      3'b000, '0, '0, '0, 8'h10, 4'b1111));
    vecs.push_back(mk(0,0,1, 4'b0100, {3'd0,3'd7,6'd0}, {16'h0,16'h0C02,32'h0}, {6'd0,6'd10,12'd0},
                      3'b000, '0, '0, '0, 8'h20, 4'b1011));
    vecs.push_back(mk(0,0,1, 4'b0100, {3'd0,3'd7,6'd0}, {16'h0,16'h0C03,32'h0}, {6'd0,6'd11,12'd0},
                      3'b000, '0, '0, '0, 8'h20, 4'b1011));
    vecs.push_back(mk(0,0,0, 4'b0100, {3'd0,3'd7,6'd0}, {16'h0,16'h0C03,32'h0}, {6'd0,6'd11,12'd0},
                      3'b001, {6'd0,3'd7}, {32'h0,16'h0C01}, {12'd0,6'd9}, 8'h10, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0100, {3'd0,3'd7,6'd0}, {16'h0,16'h0C03,32'h0}, {6'd0,6'd11,12'd0},
                      3'b001, {6'd0,3'd7}, {32'h0,16'h0C02}, {12'd0,6'd10}, 8'h10, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b001, {6'd0,3'd7}, {32'h0,16'h0C03},
                      {12'd0,6'd11}, 8'h00, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b000, '0, '0, '0, 8'h00, 4'b1111));
    // fill two FIFOs, flush with a concurrent push, then show the pointer returned to 0
    vecs.push_back(mk(0,0,1, 4'b0011, {6'd0,3'd2,3'd1}, {32'h0,16'h0F02,16'h0F01}, {12'd0,6'd2,6'd1},
                      3'b000, '0, '0, '0, 8'h05, 4'b1111));
    vecs.push_back(mk(0,0,1, 4'b0011, {6'd0,3'd2,3'd1}, {32'h0,16'h0F04,16'h0F03}, {12'd0,6'd4,6'd3},
                      3'b000, '0, '0, '0, 8'h0A, 4'b1100));
    vecs.push_back(mk(0,1,0, 4'b0100, {3'd0,3'd3,6'd0}, {16'h0,16'h0F05,32'h0}, {6'd0,6'd5,12'd0},
                      3'b000, '0, '0, '0, 8'h00, 4'b0000));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b000, '0, '0, '0, 8'h00, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b1001, {3'd2,6'd0,3'd1}, {16'h3333,32'h0,16'h1111}, {6'd3,12'd0,6'd1},
                      3'b000, '0, '0, '0, 8'h41, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b011, {3'd0,3'd2,3'd1}, {16'h0,16'h3333,16'h1111},
                      {6'd0,6'd3,6'd1}, 8'h00, 4'b1111));
    // fairness with all requesters continuously valid
    vecs.push_back(mk(0,0,0, 4'b1111, FA, FD, FR, 3'b000, '0, '0, '0, 8'h55, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b1111, FA, FD, FR, 3'b111, {3'd3,3'd2,3'd1},
                      {16'hD002,16'hD001,16'hD000}, {6'd18,6'd17,6'd16}, 8'h95, 4'b0111));
    vecs.push_back(mk(0,0,0, 4'b1111, FA, FD, FR, 3'b111, {3'd2,3'd1,3'd4},
                      {16'hD001,16'hD000,16'hD003}, {6'd17,6'd16,6'd19}, 8'h65, 4'b1011));
    vecs.push_back(mk(0,0,0, 4'b1111, FA, FD, FR, 3'b111, {3'd1,3'd4,3'd3},
                      {16'hD000,16'hD003,16'hD002}, {6'd16,6'd19,6'd18}, 8'h59, 4'b1101));
    vecs.push_back(mk(0,0,0, 4'b1111, FA, FD, FR, 3'b111, {3'd4,3'd3,3'd2},
                      {16'hD003,16'hD002,16'hD001}, {6'd19,6'd18,6'd17}, 8'h56, 4'b1110));
    // reset mid-stream, then a single push on req1
    vecs.push_back(mk(1,0,0, 4'b1111, FA, FD, FR, 3'b000, '0, '0, '0, 8'h00, 4'b0000));
    vecs.push_back(mk(0,0,0, 4'b0010, {6'd0,3'd5,3'd0}, {32'h0,16'hBEEF,16'h0}, {12'd0,6'h2A,6'd0},
                      3'b000, '0, '0, '0, 8'h04, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b001, {6'd0,3'd5}, {32'h0,16'hBEEF},
                      {12'd0,6'h2A}, 8'h00, 4'b1111));
    vecs.push_back(mk(0,0,0, 4'b0000, '0, '0, '0, 3'b000, '0, '0, '0, 8'h00, 4'b1111));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cur = vecs[i];
      cur.id = i;
      applyStimulus(cur);
    end
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; hold = 1'b0; req_valid = '0;
    for (int c = 0; c < 5 && exp_q.size() != 0; c++) @(posedge clk);
    #2;
    cmp("scoreboard_drained", -1, 64'(exp_q.size()), 64'd0);

    // single push, then wait a bounded number of edges for its grant
    @(negedge clk);
    req_valid = 4'b0100;
    req_waddr = {3'd0, 3'd6, 6'd0};
    req_wdata = {16'h0, 16'h5A5A, 32'h0};
    req_wrob  = {6'd0, 6'h15, 12'd0};
    @(negedge clk);
    req_valid = '0;
    found = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6 && !found; c++) begin
      @(posedge clk);
      #1;
      if (wen0) begin
        found = 1'b1;
        lat = c;
      end
    end
    cmp("latency_grant_seen", -2, 64'(found), 64'd1);
    cmp("latency_edges", -2, 64'(lat), 64'd1);
    cmp("latency_waddr0", -2, 64'(waddr0), 64'd6);
    cmp("latency_wdata0", -2, 64'(wdata0), 64'h5A5A);
    cmp("latency_wrob0", -2, 64'(wrob0), 64'h15);
    cmp("latency_wen12", -2, 64'({wen2, wen1}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback port arbiter between four functional-unit result producers and the three architectural register-file write ports (wen0..2 / waddr / wdata / wrob). Each producer pushes results through a valid/ready handshake into a private FIFO. Each cycle the arbiter grants up to three FIFO heads in round-robin order, never granting two writes to the same register in one cycle. It drives the register-file write ports from flops and is cleared by pipeline flush.

## Interface
- DEPTH, 2, entries per requester FIFO (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; drops all buffered results
- hold  in  1  suppresses all grants this cycle (FIFOs still accept)
- req_valid  in  4  requester i has a result
- req_ready  out  4  requester i FIFO can accept
- req_waddr  in  12  requester i dest reg at [3i+2:3i]
- req_wdata  in  64  requester i data at [16i+15:16i]
- req_wrob  in  24  requester i ROB tag at [6i+5:6i]
- wen0/wen1/wen2  out  1 each  write-port enables (registered)
- waddr0/1/2  out  3 each  write-port register index (registered)
- wdata0/1/2  out  16 each  write-port data (registered)
- wrob0/1/2  out  6 each  write-port ROB tag (registered)
- occ  out  4×($clog2(DEPTH)+1)  per-requester FIFO occupancy, packed i-major

## Operation
- Per-requester FIFO holds {waddr, wdata, wrob}. Push on posedge when req_valid[i] & req_ready[i] & !flush & !reset.
- req_ready[i] = (occ_i < DEPTH) & !flush; from registered occupancy only. Same-cycle pop does not raise ready.
- Candidates: requesters with occ_i ≥ 1, looking at the FIFO head only. An entry pushed at edge E is first a candidate in the cycle after E.
- Scan order: p, p+1, p+2, p+3 (mod 4), where p is the 2-bit round-robin pointer.
- Selection: walk the scan order and select a candidate if fewer than 3 are already selected and its waddr differs from every already-selected waddr. Otherwise skip it; it stays at the head.
- The k-th selected entry (k = 0, 1, 2 in scan order) is popped and loaded into port k: wen_k←1 and waddr_k/wdata_k/wrob_k←entry. Unused ports get wen_k←0. Their addr/data/rob fields hold their old value.
- Pointer: if ≥1 grant, p ← (index of last selected requester + 1) mod 4. Otherwise p is unchanged.
- hold=1: no selection, all wen←0, p unchanged, pushes allowed.
- At most one pop per requester per cycle. A push and a pop on the same FIFO in the same cycle leave occ unchanged.
- flush=1 (and reset=0): all FIFOs emptied, all wen←0, p←0, pushes ignored.
- reset=1: same as flush, and it overrides all other inputs. Reset values: wen0..2=0, waddr/wdata/wrob=0, occ=0, p=0, req_ready=0 during reset and 4'b1111 in the cycle after.

## Timing
- Result accepted at edge E. Earliest grant at edge E+1 (wen high in cycle E+1..E+2). The register file captures it at edge E+2.
- Grants are computed combinationally from FIFO heads and p, then registered. There is no combinational path from any req_* input to any output except req_ready ← flush.
- Sustained throughput is 3 writes/cycle with ≥3 non-empty, address-distinct FIFOs.
- Full FIFO: ready drops the cycle after the edge that made occ=DEPTH. It rises the cycle after a pop.
- Order within a requester is strictly FIFO. There is no ordering guarantee across requesters.
- A flush in the same cycle as a would-be grant: nothing is granted and the wen outputs are 0 next cycle.

## Test plan
- Reset, then all four requesters push once (waddr 1,2,3,4; wdata 16'hA001..A004; wrob 5..8). Next edge: ports 0/1/2 = req0/1/2 with wen=1, p→3. Following edge: port0 = req3 (waddr 4, wdata A004), wen1=wen2=0, p→0.
- Address conflict: req0 and req1 both push waddr 5 (wdata 11, 22), req2 pushes waddr 6, p=0. Grant 1: port0 = req0 (5,11) and port1 = req2 (6,…); p→3. Grant 2: port0 = req1 (5,22).
- Backpressure: hold=1 while req2 pushes 3 results with DEPTH=2. The first two are accepted, occ2=2, and ready[2]=0 from the next cycle. Third valid is held off. Drop hold: one pop per cycle, and ready[2]=1 one cycle after the first pop.
- Flush: fill req0/req1 to occ=2, assert flush for one cycle. Next cycle: occ=0, all wen=0, p=0, and a push during the flush is not stored.
- Fairness: req0..3 held continuously valid with distinct waddrs. Over 4 grant cycles each requester receives exactly 3 grants, and p cycles 3,2,1,0.
- Reset mid-stream: assert reset while all wen=1 and FIFOs are non-empty. Next cycle: all outputs 0 and occ=0. Then one push on req1 is granted on port0 two edges later.
